// File: rtl/pcie_reconfig_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_reconfig_mgmt_pkg
// Description : Shared definitions for the PCIe transceiver reconfiguration
//               management master: command op encodings, FSM state encoding
//               and the poll-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_reconfig_mgmt_pkg;

    // Command operation encodings (cmd_op)
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Poll counter width; POLL_LIMIT must fit, so the counter never wraps.
    localparam int unsigned POLL_CNT_W = 8;

    // Master FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BUSY = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_CHECK     = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

endpackage : pcie_reconfig_mgmt_pkg
`default_nettype wire

// File: rtl/pcie_reconfig_mgmt_master.sv
`default_nettype none
// ============================================================================
// Module      : pcie_reconfig_mgmt_master
// Description : Single-command Avalon-MM master for the transceiver
//               reconfiguration controller. Accepts read, write and poll
//               commands, waits for the controller to be idle, performs the
//               bus access and returns a one-cycle response. Poll repeats a
//               read until (readdata & mask) == (data & mask) or POLL_LIMIT
//               completed reads have been made (timeout -> rsp_error).
//
// Ports       : reconfig_xcvr_clk        - clock
//               mgmt_rst_reset           - synchronous active-high reset
//               cmd_valid/cmd_ready      - command handshake
//               cmd_op/addr/data/mask    - command fields
//               rsp_valid/data/error     - one-cycle completion
//               reconfig_busy            - controller busy, blocks access
//               reconfig_mgmt_*          - Avalon-MM master interface
//
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_reconfig_mgmt_master
    import pcie_reconfig_mgmt_pkg::*;
#(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic              reconfig_xcvr_clk,
    input  logic              mgmt_rst_reset,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    // response channel
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    // reconfiguration controller
    input  logic              reconfig_busy,
    output logic [ADDR_W-1:0] reconfig_mgmt_address,
    output logic              reconfig_mgmt_read,
    output logic              reconfig_mgmt_write,
    output logic [DATA_W-1:0] reconfig_mgmt_writedata,
    input  logic [DATA_W-1:0] reconfig_mgmt_readdata,
    input  logic              reconfig_mgmt_waitrequest
);

    localparam logic [POLL_CNT_W-1:0] c_poll_limit = POLL_CNT_W'(POLL_LIMIT);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [1:0]            r_op;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     r_mask;
    logic [DATA_W-1:0]     r_rdata;
    logic [POLL_CNT_W-1:0] r_poll_cnt;

    // ------------------------------------------------------------------------
    // Next-state / next-output signals
    // ------------------------------------------------------------------------
    state_t                w_state_nxt;
    logic                  w_capture;
    logic                  w_rsp_error_nxt;
    logic [DATA_W-1:0]     w_rsp_data_nxt;
    logic                  w_access_nxt;
    logic                  w_xfer_done;
    logic                  w_poll_match;
    logic [POLL_CNT_W-1:0] w_poll_cnt_inc;

    assign w_xfer_done    = (r_state == ST_ACCESS) && !reconfig_mgmt_waitrequest;
    assign w_poll_match   = ((r_rdata & r_mask) == (r_data & r_mask));
    assign w_poll_cnt_inc = r_poll_cnt + POLL_CNT_W'(1);
    assign w_access_nxt   = (w_state_nxt == ST_ACCESS);

    // ------------------------------------------------------------------------
    // Next-state and response logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_capture       = 1'b0;
        w_rsp_error_nxt = 1'b0;
        w_rsp_data_nxt  = '0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_capture = 1'b1;
                    if (cmd_op == OP_RSVD) begin
                        // Reserved op completes with an error and never
                        // touches the bus.
                        w_state_nxt     = ST_RESP;
                        w_rsp_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_BUSY;
                    end
                end
            end

            ST_WAIT_BUSY: begin
                if (!reconfig_busy) begin
                    w_state_nxt = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (w_xfer_done) begin
                    if (r_op == OP_POLL) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_RESP;
                        // Read data goes straight from the bus into the
                        // response so read latency does not need CHECK.
                        if (r_op == OP_READ) begin
                            w_rsp_data_nxt = reconfig_mgmt_readdata;
                        end
                    end
                end
            end

            ST_CHECK: begin
                if (w_poll_match) begin
                    w_state_nxt    = ST_RESP;
                    w_rsp_data_nxt = r_rdata;
                end else if (w_poll_cnt_inc == c_poll_limit) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_error_nxt = 1'b1;
                    w_rsp_data_nxt  = r_rdata;
                end else begin
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, datapath and registered outputs. Outputs are loaded from the
    // next-state decode so they line up with the state they belong to.
    // ------------------------------------------------------------------------
    always_ff @(posedge reconfig_xcvr_clk) begin
        if (mgmt_rst_reset) begin
            r_state                 <= ST_IDLE;
            r_op                    <= OP_READ;
            r_addr                  <= '0;
            r_data                  <= '0;
            r_mask                  <= '0;
            r_rdata                 <= '0;
            r_poll_cnt              <= '0;
            cmd_ready               <= 1'b1;
            rsp_valid               <= 1'b0;
            rsp_data                <= '0;
            rsp_error               <= 1'b0;
            reconfig_mgmt_address   <= '0;
            reconfig_mgmt_read      <= 1'b0;
            reconfig_mgmt_write     <= 1'b0;
            reconfig_mgmt_writedata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_capture) begin
                r_op       <= cmd_op;
                r_addr     <= cmd_addr;
                r_data     <= cmd_data;
                r_mask     <= cmd_mask;
                r_poll_cnt <= '0;
            end else if (r_state == ST_CHECK) begin
                r_poll_cnt <= w_poll_cnt_inc;
            end

            if (w_xfer_done) begin
                r_rdata <= reconfig_mgmt_readdata;
            end

            cmd_ready <= (w_state_nxt == ST_IDLE);
            rsp_valid <= (w_state_nxt == ST_RESP);
            rsp_error <= w_rsp_error_nxt;
            rsp_data  <= w_rsp_data_nxt;

            // Only ACCESS drives a request; staying in ACCESS re-loads the
            // same captured values, which holds them during waitrequest.
            reconfig_mgmt_read  <= w_access_nxt &&
                                   ((r_op == OP_READ) || (r_op == OP_POLL));
            reconfig_mgmt_write <= w_access_nxt && (r_op == OP_WRITE);
            if (w_access_nxt) begin
                reconfig_mgmt_address <= r_addr;
                if (r_op == OP_WRITE) begin
                    reconfig_mgmt_writedata <= r_data;
                end
            end
        end
    end

endmodule : pcie_reconfig_mgmt_master
`default_nettype wire

// File: tb/tb_pcie_reconfig_mgmt_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_reconfig_mgmt_master
// Description : Self-checking bench for pcie_reconfig_mgmt_master. Directed
//               scenarios followed by randomized commands, all checked
//               against a transaction-level model (result value, error,
//               bus-cycle counts and response latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_reconfig_mgmt_master;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              reconfig_xcvr_clk = 1'b0;
    logic              mgmt_rst_reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;
    logic              reconfig_busy;
    logic [ADDR_W-1:0] reconfig_mgmt_address;
    logic              reconfig_mgmt_read;
    logic              reconfig_mgmt_write;
    logic [DATA_W-1:0] reconfig_mgmt_writedata;
    logic [DATA_W-1:0] reconfig_mgmt_readdata;
    logic              reconfig_mgmt_waitrequest;

    int total = 0;
    int bad   = 0;

    // Read data returned by successive completed reads of one command
    logic [DATA_W-1:0] rv [0:15];

    pcie_reconfig_mgmt_master #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .POLL_LIMIT(LIMIT)
    ) u_dut (
        .reconfig_xcvr_clk        (reconfig_xcvr_clk),
        .mgmt_rst_reset           (mgmt_rst_reset),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_op                   (cmd_op),
        .cmd_addr                 (cmd_addr),
        .cmd_data                 (cmd_data),
        .cmd_mask                 (cmd_mask),
        .rsp_valid                (rsp_valid),
        .rsp_data                 (rsp_data),
        .rsp_error                (rsp_error),
        .reconfig_busy            (reconfig_busy),
        .reconfig_mgmt_address    (reconfig_mgmt_address),
        .reconfig_mgmt_read       (reconfig_mgmt_read),
        .reconfig_mgmt_write      (reconfig_mgmt_write),
        .reconfig_mgmt_writedata  (reconfig_mgmt_writedata),
        .reconfig_mgmt_readdata   (reconfig_mgmt_readdata),
        .reconfig_mgmt_waitrequest(reconfig_mgmt_waitrequest)
    );

    always #5 reconfig_xcvr_clk = ~reconfig_xcvr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command (caller sits at a negedge with the DUT idle), act as
    // the Avalon slave, and compare everything against the model.
    //   b : cycles reconfig_busy is held high after acceptance
    //   w : waitrequest-high cycles before every access completes
    task automatic run_txn(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] mask,
                           input int b, input int w);
        int e_reads, e_writes, e_lat, e_rdhi, e_wrhi, k;
        logic e_err;
        logic [DATA_W-1:0] e_data;
        int cyc, n_rd, n_wr, hi_rd, hi_wr, both, stab_err, addr_err, wd_err;
        int w_left, first_acc, n_rsp;
        logic done, prev_stall, prev_rd, prev_wr, o_err;
        logic [ADDR_W-1:0] prev_addr;
        logic [DATA_W-1:0] prev_wd, o_data;
        int o_lat;

        // ---- transaction-level model ----
        e_reads = 0; e_writes = 0; e_rdhi = 0; e_wrhi = 0; e_err = 1'b0; e_data = '0;
        case (op)
            2'b11: begin e_err = 1'b1; e_lat = 1; end
            2'b01: begin e_writes = 1; e_wrhi = w + 1; e_lat = b + w + 3; end
            2'b00: begin e_reads = 1; e_rdhi = w + 1; e_data = rv[0]; e_lat = b + w + 3; end
            default: begin
                k = LIMIT; e_err = 1'b1;
                for (int i = 0; i < LIMIT; i++) begin
                    if ((rv[i] & mask) == (data & mask)) begin
                        k = i + 1; e_err = 1'b0; break;
                    end
                end
                e_reads = k; e_rdhi = k * (w + 1); e_data = rv[k-1];
                e_lat = b + k * (w + 3) + 1;
            end
        endcase

        // ---- drive command ----
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        reconfig_busy = (b > 0);
        reconfig_mgmt_waitrequest = 1'b0;
        @(posedge reconfig_xcvr_clk);

        cyc = 0; done = 1'b0; n_rd = 0; n_wr = 0; hi_rd = 0; hi_wr = 0; both = 0;
        stab_err = 0; addr_err = 0; wd_err = 0; w_left = w; first_acc = -1; n_rsp = 0;
        prev_stall = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wd = '0;
        o_err = 1'b0; o_data = '0; o_lat = -1;

        while (!done && cyc < 600) begin
            @(negedge reconfig_xcvr_clk);
            cyc++;
            // Garbage on the command port must be ignored while busy
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_addr  = ADDR_W'($urandom);
            cmd_data  = $urandom;
            cmd_mask  = $urandom;
            reconfig_busy = (cyc <= b);

            if (prev_stall &&
                (reconfig_mgmt_address !== prev_addr || reconfig_mgmt_read !== prev_rd ||
                 reconfig_mgmt_write !== prev_wr || reconfig_mgmt_writedata !== prev_wd))
                stab_err++;
            if (reconfig_mgmt_read && reconfig_mgmt_write) both++;

            if (reconfig_mgmt_read || reconfig_mgmt_write) begin
                if (first_acc < 0) first_acc = cyc;
                if (reconfig_mgmt_read)  hi_rd++;
                if (reconfig_mgmt_write) hi_wr++;
                if (reconfig_mgmt_address !== addr) addr_err++;
                if (reconfig_mgmt_write && reconfig_mgmt_writedata !== data) wd_err++;
                if (w_left > 0) begin
                    reconfig_mgmt_waitrequest = 1'b1;
                    reconfig_mgmt_readdata    = $urandom;
                    w_left--;
                    prev_stall = 1'b1;
                end else begin
                    reconfig_mgmt_waitrequest = 1'b0;
                    prev_stall = 1'b0;
                    w_left = w;
                    if (reconfig_mgmt_read) begin
                        reconfig_mgmt_readdata = rv[n_rd % 16];
                        n_rd++;
                    end else begin
                        reconfig_mgmt_readdata = $urandom;
                        n_wr++;
                    end
                end
            end else begin
                reconfig_mgmt_waitrequest = 1'($urandom_range(0, 1));
                reconfig_mgmt_readdata    = $urandom;
                prev_stall = 1'b0;
            end
            prev_addr = reconfig_mgmt_address; prev_rd = reconfig_mgmt_read;
            prev_wr   = reconfig_mgmt_write;   prev_wd = reconfig_mgmt_writedata;

            if (rsp_valid) begin
                done = 1'b1; n_rsp++;
                o_lat = cyc; o_data = rsp_data; o_err = rsp_error;
                cmd_valid = 1'b0;
                reconfig_mgmt_waitrequest = 1'b0;
            end
        end
        chk("rsp_seen_in_budget", done, 1);

        @(negedge reconfig_xcvr_clk);
        reconfig_busy = 1'b0;
        chk("rsp_pulse_one_cycle", rsp_valid, 0);
        chk("cmd_ready_after_rsp", cmd_ready, 1);
        chk("bus_idle_after_rsp", {reconfig_mgmt_read, reconfig_mgmt_write}, 0);

        chk("rsp_data", o_data, e_data);
        chk("rsp_error", o_err, e_err);
        chk("rsp_latency", o_lat, e_lat);
        chk("completed_reads", n_rd, e_reads);
        chk("completed_writes", n_wr, e_writes);
        chk("read_high_cycles", hi_rd, e_rdhi);
        chk("write_high_cycles", hi_wr, e_wrhi);
        chk("rd_wr_together", both, 0);
        chk("stable_under_wait", stab_err, 0);
        chk("address_value", addr_err, 0);
        chk("writedata_value", wd_err, 0);
        if (op != 2'b11) chk("first_access_cycle", first_acc, b + 2);
    endtask

    initial begin
        logic [1:0]        r_op;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_data, r_mask;

        mgmt_rst_reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
        reconfig_busy = 1'b0; reconfig_mgmt_readdata = '0; reconfig_mgmt_waitrequest = 1'b0;
        for (int i = 0; i < 16; i++) rv[i] = '0;

        // ---- reset state ----
        repeat (3) @(posedge reconfig_xcvr_clk);
        @(negedge reconfig_xcvr_clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_rd_wr", {reconfig_mgmt_read, reconfig_mgmt_write}, 0);
        chk("rst_address", reconfig_mgmt_address, 0);
        chk("rst_writedata", reconfig_mgmt_writedata, 0);
        mgmt_rst_reset = 1'b0;

        // ---- write 0x08 / 0xA5 with 3 waitrequest cycles ----
        run_txn(2'b01, 7'h08, 32'h0000_00A5, 32'h0, 0, 3);

        // ---- reset during a stalled read ----
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 7'h22; cmd_data = '0; cmd_mask = '0;
        reconfig_mgmt_waitrequest = 1'b1;
        @(posedge reconfig_xcvr_clk);
        @(negedge reconfig_xcvr_clk);
        cmd_valid = 1'b0;
        @(negedge reconfig_xcvr_clk);
        chk("midacc_read_high", reconfig_mgmt_read, 1);
        mgmt_rst_reset = 1'b1;
        @(posedge reconfig_xcvr_clk);
        @(negedge reconfig_xcvr_clk);
        mgmt_rst_reset = 1'b0;
        reconfig_mgmt_waitrequest = 1'b0;
        chk("midacc_rd_wr_dropped", {reconfig_mgmt_read, reconfig_mgmt_write}, 0);
        chk("midacc_cmd_ready", cmd_ready, 1);
        chk("midacc_rsp_valid", rsp_valid, 0);
        chk("midacc_address", reconfig_mgmt_address, 0);
        chk("midacc_writedata", reconfig_mgmt_writedata, 0);

        // ---- read 0x10, no busy, no wait ----
        rv[0] = 32'hDEAD_BEEF;
        run_txn(2'b00, 7'h10, 32'h0, 32'h0, 0, 0);

        // ---- read with busy held 10 cycles ----
        rv[0] = 32'h1234_5678;
        run_txn(2'b00, 7'h3C, 32'h0, 32'h0, 10, 0);

        // ---- poll matching on the fourth read (equal to the limit) ----
        rv[0] = 32'h100; rv[1] = 32'h100; rv[2] = 32'h100; rv[3] = 32'h000;
        run_txn(2'b10, 7'h05, 32'h000, 32'h100, 0, 0);

        // ---- poll that never matches: timeout after LIMIT reads ----
        for (int i = 0; i < 16; i++) rv[i] = 32'h100;
        run_txn(2'b10, 7'h05, 32'h000, 32'h100, 1, 1);

        // ---- reserved op ----
        run_txn(2'b11, 7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

        // ---- randomized commands ----
        for (int t = 0; t < 40; t++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = ADDR_W'($urandom);
            r_data = $urandom;
            r_mask = $urandom;
            for (int i = 0; i < 16; i++)
                rv[i] = ($urandom_range(0, 3) == 0) ? ((r_data & r_mask) | ($urandom & ~r_mask))
                                                    : $urandom;
            run_txn(r_op, r_addr, r_data, r_mask, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pcie_reconfig_mgmt_master
`default_nettype wire

// File: doc/pcie_reconfig_mgmt_master.md
PCIE_RECONFIG_MGMT_MASTER -- requirements
Module: pcie_reconfig_mgmt_master

Interface
REQ-001 The block SHALL have one clock, reconfig_xcvr_clk, and a synchronous, active-high reset, mgmt_rst_reset.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- ADDR_W, 7, management address width.
- DATA_W, 32, management data width.
- POLL_LIMIT, 255, maximum completed poll reads before timeout (range 1..255).

REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- reconfig_xcvr_clk, in, 1, clock.
- mgmt_rst_reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when high with cmd_valid.
- cmd_op, in, 2, operation: 00 read, 01 write, 10 poll, 11 reserved.
- cmd_addr, in, ADDR_W, target register address.
- cmd_data, in, DATA_W, write data, or poll compare value.
- cmd_mask, in, DATA_W, poll compare mask.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_data, out, DATA_W, read result.
- rsp_error, out, 1, timeout or reserved op.
- reconfig_busy, in, 1, controller busy.
- reconfig_mgmt_address, out, ADDR_W, Avalon-MM address.
- reconfig_mgmt_read, out, 1, Avalon-MM read.
- reconfig_mgmt_write, out, 1, Avalon-MM write.
- reconfig_mgmt_writedata, out, DATA_W, Avalon-MM write data.
- reconfig_mgmt_readdata, in, DATA_W, Avalon-MM read data.
- reconfig_mgmt_waitrequest, in, 1, Avalon-MM stall.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, WAIT_BUSY, ACCESS, CHECK, RESP.
REQ-005 cmd_ready SHALL be high only in IDLE; cmd_valid&&cmd_ready SHALL capture cmd_op, cmd_addr, cmd_data and cmd_mask, and clear the poll counter.
REQ-006 On acceptance, reserved op 11 SHALL go to RESP with rsp_error=1 and no bus access; every other op SHALL go to WAIT_BUSY.
REQ-007 WAIT_BUSY SHALL remain while reconfig_busy=1 and SHALL go to ACCESS on the first cycle reconfig_busy=0; waiting for busy has no timeout.
REQ-008 In ACCESS:
- reconfig_mgmt_write SHALL be 1 for write.
- reconfig_mgmt_read SHALL be 1 for read and poll.
- Read and write SHALL never be high together, and SHALL be 0 in every other state.
REQ-009 Address, read, write and writedata SHALL hold stable while reconfig_mgmt_waitrequest=1.
REQ-010 The transfer SHALL complete on the first ACCESS cycle with waitrequest=0, and reconfig_mgmt_readdata SHALL be sampled on that cycle.
REQ-011 On completion, read and write SHALL go to RESP, and poll SHALL go to CHECK.
REQ-012 CHECK SHALL increment the poll counter, then:
- (rdata & mask) == (data & mask): go to RESP, rsp_error=0.
- Otherwise, if the incremented counter equals POLL_LIMIT: go to RESP, rsp_error=1.
- Otherwise: go back to WAIT_BUSY.
REQ-013 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_data and rsp_error SHALL be valid only while rsp_valid=1.
REQ-014 rsp_data SHALL be the last sampled readdata for read and poll (including a poll timeout), and 0 for write and reserved ops.
REQ-015 With busy=0 and waitrequest=0, latency SHALL be:
- read/write: accept at edge N, read/write high in cycle N+2, rsp_valid in cycle N+3.
- poll matching on its first read: rsp_valid in cycle N+4.
REQ-016 The poll counter SHALL be 8 bits and SHALL not wrap, because POLL_LIMIT<=255 bounds it.
REQ-017 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-018 With mgmt_rst_reset=1 at an edge, the next state SHALL be IDLE, and:
- cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_error=0.
- read=0; write=0; address=0; writedata=0.
- Poll counter and captured command cleared.
REQ-019 Reset mid-ACCESS SHALL drop read/write at the next edge; this is legal only because the reconfiguration controller shares mgmt_rst_reset.

Structure
REQ-020 A shared package pcie_reconfig_mgmt_pkg SHALL hold the op encodings (OP_READ, OP_WRITE, OP_POLL, OP_RSVD) and the FSM state encoding.
REQ-021 The block SHALL be a single module with no sub-module; all outputs SHALL be registered.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset mid-ACCESS: read/write=0 and cmd_ready=1 one edge after reset.
- Write addr 0x08 data 0x0000_00A5, waitrequest high 3 cycles: write high 4 cycles with stable addr/data; rsp_valid, rsp_error=0, rsp_data=0.
- Read addr 0x10, readdata 0xDEAD_BEEF, busy low, waitrequest low: read in cycle N+2; rsp_valid in cycle N+3 with rsp_data=0xDEAD_BEEF.
- Read with reconfig_busy held high 10 cycles: no read until busy falls; read starts the cycle after.
- Poll mask 0x100, value 0x000, readdata 0x100 for three reads then 0x000: exactly 4 reads; rsp_error=0, rsp_data=0x000.
- Poll with POLL_LIMIT=4, never matching: exactly 4 reads; rsp_error=1. Reserved op: rsp_error=1 with zero bus activity.
